// File: rtl/cape_sng_seq.sv
// CAPE-counter stochastic number generator with start/busy/done run control,
// downstream stall, early termination and runtime precision truncation.
module cape_sng_seq #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      corr,
  input  logic                      et_en,
  input  logic [WIDTH-1:0]          trunc,
  input  logic [WIDTH-1:0]          Bxs [NUM_INPUTS],
  input  logic                      hold,
  output logic                      busy,
  output logic [NUM_INPUTS-1:0]     Xs,
  output logic                      xs_valid,
  output logic                      done,
  output logic [WIDTH*NUM_INPUTS:0] run_len
);

  localparam int CW = WIDTH * NUM_INPUTS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                           state_r, state_nxt_s;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] b_r;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] tz_s;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] v_s;
  logic [WIDTH-1:0]                 tz_all_s;
  logic                             corr_r;
  logic                             et_en_r;
  logic [CW-1:0]                    cnt_r;
  logic [CW-1:0]                    bp_s;
  logic [CW-1:0]                    cnt_nxt_s;
  logic [CW:0]                      sum_s;
  logic [CW:0]                      len_r;
  logic [CW:0]                      run_len_r;
  logic                             ovf_s;
  logic                             advance_s;
  logic [NUM_INPUTS-1:0]            xs_s;

  // Trailing-zero masks: tz[i][j] set when operand bits j..0 are all zero.
  always_comb begin
    tz_s     = '0;
    tz_all_s = {WIDTH{1'b1}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        tz_s[i][j]  = ~|(b_r[i] << (WIDTH - 1 - j));
        tz_all_s[j] = tz_all_s[j] & tz_s[i][j];
      end
    end
  end

  // Bypass mask; correlated mode never counts above the low WIDTH bits.
  always_comb begin
    bp_s = '0;
    for (int k = 0; k < CW; k++) begin
      if (corr_r) begin
        if (k < WIDTH) begin
          bp_s[k] = et_en_r & tz_all_s[k % WIDTH];
        end else begin
          bp_s[k] = 1'b1;
        end
      end else begin
        bp_s[k] = et_en_r & tz_s[k % NUM_INPUTS][k / NUM_INPUTS];
      end
    end
  end

  // Forcing bypassed bits high lets the carry ripple straight past them.
  always_comb begin
    sum_s     = {1'b0, cnt_r | bp_s} + {{CW{1'b0}}, 1'b1};
    ovf_s     = sum_s[CW];
    cnt_nxt_s = sum_s[CW-1:0] & ~bp_s;
    advance_s = (state_r == ST_RUN) && !hold;
  end

  // Per-channel compare values and stream bits.
  always_comb begin
    v_s  = '0;
    xs_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (corr_r) begin
          v_s[i][j] = cnt_r[j];
        end else begin
          v_s[i][j] = cnt_r[j*NUM_INPUTS+i];
        end
      end
      if (state_r == ST_RUN) begin
        xs_s[i] = (v_s[i] < b_r[i]);
      end else begin
        xs_s[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a stalled cycle never terminates the run.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (advance_s && ovf_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, counter advance and length accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_r       <= '0;
      corr_r    <= 1'b0;
      et_en_r   <= 1'b0;
      cnt_r     <= '0;
      len_r     <= '0;
      run_len_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              b_r[i] <= Bxs[i] & ~trunc;
            end
            corr_r  <= corr;
            et_en_r <= et_en;
            cnt_r   <= '0;
            len_r   <= '0;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            cnt_r <= cnt_nxt_s;
            len_r <= len_r + {{CW{1'b0}}, 1'b1};
            if (ovf_s) begin
              run_len_r <= len_r + {{CW{1'b0}}, 1'b1};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy     = (state_r == ST_RUN);
    xs_valid = advance_s;
    done     = (state_r == ST_DONE);
    Xs       = xs_s;
    run_len  = run_len_r;
  end

endmodule
